mem_dump: RTL and testbench

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump.sv | 96 +++++++++
 tb/tb_mem_dump.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump.sv
// Streams WORD_COUNT consecutive 32-bit words out of a synchronous-read data memory,
// one word per valid/ready handshake, starting at a word-aligned base address.
module mem_dump #(
  parameter int WORD_COUNT_W = 8
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    START,
  input  logic [31:0]             BASE_ADDR,
  input  logic [WORD_COUNT_W-1:0] WORD_COUNT,
  input  logic                    ABORT,
  output logic [31:0]             MEM_ADDR,
  output logic                    MEM_RD_EN,
  input  logic [31:0]             MEM_RDATA,
  output logic [31:0]             OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [WORD_COUNT_W-1:0] SENT
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PRESENT, FINISH} state_t;

  state_t                  state_reg, state_next;
  logic [31:0]             addr_reg, addr_next;
  logic [31:0]             data_reg, data_next;
  logic [WORD_COUNT_W-1:0] remaining_reg, remaining_next;
  logic [WORD_COUNT_W-1:0] sent_reg, sent_next;

  // The low address bits are forced to zero, so they are intentionally unused.
  logic unused_base_bits;
  assign unused_base_bits = ^BASE_ADDR[1:0];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      data_reg      <= '0;
      remaining_reg <= '0;
      sent_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      remaining_reg <= remaining_next;
      sent_reg      <= sent_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    remaining_next = remaining_reg;
    sent_next      = sent_reg;
    case (state_reg)
      IDLE: begin
        if (START) begin
          addr_next      = {BASE_ADDR[31:2], 2'b00};
          remaining_next = WORD_COUNT;
          sent_next      = '0;
          state_next     = (WORD_COUNT == '0) ? FINISH : REQ;
        end
      end
      REQ:  state_next = WAIT;
      WAIT: begin
        data_next  = MEM_RDATA;
        state_next = PRESENT;
      end
      PRESENT: begin
        if (OUT_READY) begin
          sent_next      = sent_reg + WORD_COUNT_W'(1);
          remaining_next = remaining_reg - WORD_COUNT_W'(1);
          addr_next      = addr_reg + 32'd4;
          state_next     = (remaining_reg == WORD_COUNT_W'(1)) ? FINISH : REQ;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort only redirects the state; an accepted word still updates the counters.
    if (ABORT && (state_reg != IDLE)) begin
      state_next = IDLE;
    end
  end

  assign MEM_ADDR  = addr_reg;
  assign MEM_RD_EN = (state_reg == REQ);
  assign OUT_DATA  = data_reg;
  assign OUT_VALID = (state_reg == PRESENT);
  assign BUSY      = (state_reg != IDLE);
  assign DONE      = (state_reg == FINISH);
  assign SENT      = sent_reg;

endmodule

// File: tb/tb_mem_dump.sv
// Self-checking bench for mem_dump: directed vector table, hand-written corner
// sequences and randomized dumps checked against a transaction-level model.
module tb_mem_dump;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, out_ready;
  logic [31:0]   base_addr, mem_addr, mem_rdata, out_data;
  logic [W-1:0]  word_count, sent;
  logic          mem_rd_en, out_valid, busy, done;
  logic [31:0]   mem [256];
  int            checks = 0;
  int            fails  = 0;
  int            cyc    = 0;

  mem_dump #(.WORD_COUNT_W(W)) dut (
    .CLK(clk), .RESET_N(reset_n), .START(start), .BASE_ADDR(base_addr),
    .WORD_COUNT(word_count), .ABORT(abort), .MEM_ADDR(mem_addr),
    .MEM_RD_EN(mem_rd_en), .MEM_RDATA(mem_rdata), .OUT_DATA(out_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .BUSY(busy), .DONE(done),
    .SENT(sent)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; read data is garbage unless a read was strobed.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[9:2]];
    else           mem_rdata <= $urandom;
  end

  typedef struct {
    logic [31:0] base;
    int          count;
    int          stall;
    int          abort_word;
    bit          preload;
    logic [31:0] pre0, pre1, pre2;
    int          exp_sent;
    int          exp_done;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] word_addr(input logic [31:0] base, input int i);
    return {base[31:2], 2'b00} + 32'(i) * 32'd4;
  endfunction

  // One complete dump: model expects word i at aligned base + 4*i, read strobe one
  // cycle after the triggering edge, valid three cycles after it, DONE right after
  // the last handshake unless aborted.
  task automatic run_dump(input logic [31:0] base, input int count, input int stall,
                          input int abort_word, input int exp_sent, input int exp_done);
    int nreq = 0, nacc = 0, ndone = 0, last_evt, stall_ctr = 0, stall_tgt;
    bit prev_valid = 0, finished = 0, aborting = 0;
    logic [31:0] prev_data = '0, a;
    start = 1'b1; base_addr = base; word_count = W'(count); abort = 1'b0; out_ready = 1'b0;
    last_evt = cyc;
    tick();
    stall_tgt = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    for (int t = 0; t < 4000 && !finished; t++) begin
      if (aborting) begin
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_sent", 32'(sent), exp_sent);
        finished = 1;
      end else begin
        if (mem_rd_en) begin
          if (nreq >= count) chk("rd_en_excess", 32'(mem_rd_en), 0);
          else begin
            chk("mem_addr", mem_addr, word_addr(base, nreq));
            chk("rd_latency", cyc, last_evt + 1);
          end
          nreq++;
        end
        if (out_valid) begin
          if (!prev_valid) begin
            a = word_addr(base, nacc);
            chk("valid_latency", cyc, last_evt + 3);
            chk("out_data", out_data, mem[a[9:2]]);
          end else begin
            chk("data_stable", out_data, prev_data);
          end
        end
        if (done) begin
          ndone++;
          chk("done_latency", cyc, last_evt + 1);
          chk("done_words", nacc, count);
          start = 1'b0;
          tick();
          chk("idle_after_done", 32'(busy), 0);
          chk("done_width", 32'(done), 0);
          chk("sent", 32'(sent), exp_sent);
          finished = 1;
        end else begin
          prev_valid = out_valid;
          prev_data  = out_data;
          start      = 1'($urandom_range(0, 1));
          base_addr  = $urandom;
          word_count = W'($urandom);
          if (out_valid) begin
            if (stall_ctr >= stall_tgt) begin
              out_ready = 1'b1;
              last_evt  = cyc;
              if (nacc == abort_word) begin abort = 1'b1; aborting = 1; end
              nacc++;
              stall_ctr  = 0;
              stall_tgt  = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
              prev_valid = 0;
            end else begin
              out_ready = 1'b0;
              stall_ctr++;
            end
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
          tick();
        end
      end
    end
    if (!finished) begin
      checks++; fails++;
      $display("FAIL timeout: dump base=0x%08h count=%0d never finished", base, count);
      start = 1'b0; abort = 1'b0;
    end
    chk("done_count", ndone, exp_done);
    $display("dump base=0x%08h count=%0d abort_at=%0d sent=%0d done_pulses=%0d",
             base, count, abort_word, sent, ndone);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'h0000_0000, 1,   0, -1, 1, 32'h2,  32'h0,  32'h0,  1,   1};
    vecs[1] = '{32'h0000_0003, 3,   5, -1, 1, 32'h11, 32'h22, 32'h33, 3,   1};
    vecs[2] = '{32'h0000_0040, 0,   0, -1, 0, 32'h0,  32'h0,  32'h0,  0,   1};
    vecs[3] = '{32'hFFFF_FFFC, 2,   1, -1, 0, 32'h0,  32'h0,  32'h0,  2,   1};
    vecs[4] = '{32'h0000_0010, 4,   1,  1, 0, 32'h0,  32'h0,  32'h0,  2,   0};
    vecs[5] = '{32'h0000_0100, 255, 0, -1, 0, 32'h0,  32'h0,  32'h0,  255, 1};

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset_n = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    base_addr = 32'h1234_5678; word_count = W'(5);
    repeat (3) tick();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sent", 32'(sent), 0);
    start = 1'b0; reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].preload) begin
        mem[0] = vecs[i].pre0; mem[1] = vecs[i].pre1; mem[2] = vecs[i].pre2;
      end
      run_dump(vecs[i].base, vecs[i].count, vecs[i].stall, vecs[i].abort_word,
               vecs[i].exp_sent, vecs[i].exp_done);
    end

    // ABORT in IDLE is ignored and START is accepted; ABORT in REQ returns to IDLE.
    start = 1'b1; abort = 1'b1; base_addr = 32'h0000_0080; word_count = W'(2);
    tick();
    chk("idle_abort_busy", 32'(busy), 1);
    chk("idle_abort_rd_en", 32'(mem_rd_en), 1);
    chk("idle_abort_addr", mem_addr, 32'h80);
    chk("idle_abort_sent", 32'(sent), 0);
    start = 1'b0;
    tick();
    chk("req_abort_busy", 32'(busy), 0);
    chk("req_abort_done", 32'(done), 0);
    abort = 1'b0;
    $display("abort sequence base=0x00000080 count=2 sent=%0d", sent);

    // Reset during WAIT of a 3-word dump clears everything, START held high meanwhile.
    start = 1'b1; base_addr = 32'h0000_0020; word_count = W'(3);
    tick();
    tick();
    chk("wait_busy", 32'(busy), 1);
    chk("wait_rd_en", 32'(mem_rd_en), 0);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_sent", 32'(sent), 0);
    reset_n = 1'b1; start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    $display("reset sequence base=0x00000020 count=3 sent=%0d", sent);

    for (int r = 0; r < 20; r++) begin
      logic [31:0] b;
      int cnt, aw, es, ed;
      b   = $urandom;
      cnt = int'($urandom_range(0, 6));
      aw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
      if (aw >= cnt) aw = -1;
      es  = (aw >= 0) ? aw + 1 : cnt;
      ed  = (aw >= 0) ? 0 : 1;
      run_dump(b, cnt, -1, aw, es, ed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
